// File: rtl/pm_pkg.sv
// Shared definitions for the PM sequential-multiplier scheduler slice.
package pm_pkg;

  localparam int N           = 4;
  localparam int WL          = 2 * N;
  localparam int CLR_CYC_DEF = 1;
  localparam int LAT_DEF     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pm_seq_scheduler_if.sv
// Requester, result and multiplier-side signals of the scheduler.
// master = scheduler side, slave = producers/consumer/multiplier side.
interface pm_seq_scheduler_if #(
  parameter int WL = pm_pkg::WL
);
  logic          req0_valid, req0_ready;
  logic [WL-1:0] req0_x, req0_y;
  logic          req1_valid, req1_ready;
  logic [WL-1:0] req1_x, req1_y;

  logic            res_valid, res_ready, res_id;
  logic [2*WL-1:0] res_z;

  logic [WL-1:0]   mul_x, mul_y;
  logic            mul_rst;
  logic [2*WL-1:0] mul_z;

  logic busy;

  modport master (
    input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
    input  res_ready, mul_z,
    output req0_ready, req1_ready, res_valid, res_z, res_id,
    output mul_x, mul_y, mul_rst, busy
  );

  modport slave (
    output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
    output res_ready, mul_z,
    input  req0_ready, req1_ready, res_valid, res_z, res_id,
    input  mul_x, mul_y, mul_rst, busy
  );
endinterface

// File: rtl/pm_seq_scheduler_rr_arb2.sv
// Two-way round-robin arbiter, combinational; pointer owned by the caller.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  // ptr only decides a tie; a lone request always wins
  always_comb begin
    gnt     = 2'b00;
    gnt_idx = (req == 2'b11) ? ptr : req[1];
    gnt[gnt_idx] = |req;
  end

endmodule

// File: rtl/pm_seq_scheduler.sv
// Shares one online signed-digit multiplier between two requesters:
// grants round-robin, pulses the multiplier reset, counts out its latency
// and returns the tagged product on a valid/ready port.
module pm_seq_scheduler #(
  parameter int N       = pm_pkg::N,
  parameter int CLR_CYC = pm_pkg::CLR_CYC_DEF,
  parameter int LAT     = pm_pkg::LAT_DEF
) (
  input logic                clk,
  input logic                rst,
  pm_seq_scheduler_if.master bus
);
  import pm_pkg::*;

  localparam int OPW = 2 * N;
  localparam int CW  = $clog2(imax(LAT, CLR_CYC) + 1);

  state_e        state, nxt;
  logic [CW-1:0] cnt;
  logic          ptr, id, last, accept, gnt_idx;
  logic [1:0]    gnt;

  assign last     = (cnt == CW'(1));
  assign bus.busy = (state != IDLE);

  rr_arb2 u_arb (
    .req     ({bus.req1_valid, bus.req0_valid}),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // next state and request handshake; ready is masked while in reset
  always_comb begin
    nxt            = state;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state)
      IDLE: if (rst) begin
        bus.req0_ready = gnt[0];
        bus.req1_ready = gnt[1];
        accept         = |gnt;
        if (accept) nxt = CLEAR;
      end
      CLEAR:   if (last) nxt = RUN;
      RUN:     if (last) nxt = HOLD;
      HOLD:    if (bus.res_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // operand latch, phase counter, multiplier reset and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mul_x     <= '0;
      bus.mul_y     <= '0;
      bus.mul_rst   <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_z     <= '0;
      bus.res_id    <= 1'b0;
      cnt           <= '0;
      ptr           <= 1'b0;
      id            <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          bus.mul_x <= gnt_idx ? bus.req1_x : bus.req0_x;
          bus.mul_y <= gnt_idx ? bus.req1_y : bus.req0_y;
          id        <= gnt_idx;
          ptr       <= ~gnt_idx;
          cnt       <= CW'(CLR_CYC);
        end
        CLEAR: begin
          if (last) begin
            cnt         <= CW'(LAT);
            bus.mul_rst <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RUN: begin
          if (last) begin
            bus.res_z     <= bus.mul_z;
            bus.res_id    <= id;
            bus.res_valid <= 1'b1;
            cnt           <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: if (bus.res_ready) begin
          bus.res_valid <= 1'b0;
          bus.mul_rst   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // product width must match the operand width
  logic [2*OPW-1:0] z_w;
  assign z_w = bus.mul_z;
  logic unused_ok;
  assign unused_ok = ^z_w;

endmodule

// File: tb/tb_pm_seq_scheduler.sv
// Random and directed stimulus against a queue-based reference model.
module tb_pm_seq_scheduler;
  import pm_pkg::*;

  localparam int CLR = CLR_CYC_DEF, LT = LAT_DEF, CLR2 = 2, LT2 = 1;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, fails = 0;

  pm_seq_scheduler_if #(.WL(WL)) bus ();
  pm_seq_scheduler_if #(.WL(WL)) bus2 ();

  pm_seq_scheduler #(.N(N), .CLR_CYC(CLR), .LAT(LT)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  pm_seq_scheduler #(.N(N), .CLR_CYC(CLR2), .LAT(LT2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  // stimulus state (written only by the main process)
  logic          v[2];
  logic [WL-1:0] x[2], y[2], dx[2], dy[2];
  bit            dpend[2];
  int            mode[2];
  int            rr_mode;
  logic          rdy;
  logic          v2;
  logic [WL-1:0] x2, y2;

  assign bus.req0_valid  = v[0];
  assign bus.req0_x      = x[0];
  assign bus.req0_y      = y[0];
  assign bus.req1_valid  = v[1];
  assign bus.req1_x      = x[1];
  assign bus.req1_y      = y[1];
  assign bus.res_ready   = rdy;
  assign bus2.req0_valid = v2;
  assign bus2.req0_x     = x2;
  assign bus2.req0_y     = y2;
  assign bus2.req1_valid = 1'b0;
  assign bus2.req1_x     = '0;
  assign bus2.req1_y     = '0;
  assign bus2.res_ready  = 1'b1;

  // stub multipliers: product {x,y} valid once LAT cycles of mul_rst=1 elapse
  logic [3:0] sc1 = '0, sc2 = '0;
  always @(posedge clk) begin
    sc1 <= bus.mul_rst  ? ((sc1 == 4'hf) ? sc1 : sc1 + 4'd1) : 4'd0;
    sc2 <= bus2.mul_rst ? ((sc2 == 4'hf) ? sc2 : sc2 + 4'd1) : 4'd0;
  end
  assign bus.mul_z  = (bus.mul_rst && sc1 >= 4'(LT - 1)) ? {bus.mul_x, bus.mul_y} : '0;
  assign bus2.mul_z = (bus2.mul_rst && sc2 >= 4'(LT2 - 1)) ? {bus2.mul_x, bus2.mul_y} : '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // reference model: in-flight op queue, pointer, last operands
  typedef struct {
    logic          id;
    logic [WL-1:0] x, y;
    int            acc;
  } op_t;
  op_t           q[$];
  op_t           op;
  int            ids[$];
  logic [15:0]   zlog[$];
  logic          mptr;
  logic [WL-1:0] lx, ly;
  bit            hs[2];
  bit            m_idle, m_e0, m_e1, m_rv;
  int            m_age, hs_res = -1000, acc_gap = -1;

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      mptr = 1'b0; lx = '0; ly = '0;
      hs[0] = 1'b0; hs[1] = 1'b0;
    end else begin
      m_idle = (q.size() == 0);
      m_age  = m_idle ? 0 : cyc - q[0].acc;
      m_e0   = m_idle && v[0] && (!v[1] || !mptr);
      m_e1   = m_idle && v[1] && (!v[0] || mptr);
      m_rv   = !m_idle && (m_age >= CLR + LT + 1);
      chk("busy", bus.busy, !m_idle);
      chk("req0_ready", bus.req0_ready, m_e0);
      chk("req1_ready", bus.req1_ready, m_e1);
      chk("mul_rst", bus.mul_rst, !m_idle && (m_age > CLR));
      chk("res_valid", bus.res_valid, m_rv);
      if (m_idle) begin
        chk("mul_x_idle", bus.mul_x, lx);
        chk("mul_y_idle", bus.mul_y, ly);
      end else begin
        chk("mul_x", bus.mul_x, q[0].x);
        chk("mul_y", bus.mul_y, q[0].y);
      end
      if (m_rv) begin
        chk("res_z", bus.res_z, {q[0].x, q[0].y});
        chk("res_id", bus.res_id, q[0].id);
        if (rdy) begin
          ids.push_back(int'(q[0].id));
          zlog.push_back(bus.res_z);
          hs_res = cyc;
          void'(q.pop_front());
        end
      end
      hs[0] = m_e0;
      hs[1] = m_e1;
      if (m_e0 || m_e1) begin
        op.id  = m_e1;
        op.x   = m_e1 ? x[1] : x[0];
        op.y   = m_e1 ? y[1] : y[0];
        op.acc = cyc;
        q.push_back(op);
        mptr    = ~op.id;
        lx      = op.x;
        ly      = op.y;
        acc_gap = cyc - hs_res;
      end
    end
  end

  // one cycle of stimulus: requesters hold until accepted, then reload
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (hs[k]) v[k] = 1'b0;
      if (!v[k] && rst) begin
        if (dpend[k]) begin
          v[k] = 1'b1; x[k] = dx[k]; y[k] = dy[k]; dpend[k] = 1'b0;
        end else if (mode[k] == 1 || (mode[k] == 2 && $urandom_range(0, 2) == 0)) begin
          v[k] = 1'b1; x[k] = WL'($urandom); y[k] = WL'($urandom);
        end
      end
    end
    rdy = (rr_mode == 2) ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
  endtask

  task automatic chk_reset();
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_z", bus.res_z, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mul_rst", bus.mul_rst, 0);
    chk("rst_mul_x", bus.mul_x, 0);
    chk("rst_mul_y", bus.mul_y, 0);
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk_reset();
    v[0] = 1'b0; v[1] = 1'b0;
    mode[0] = 0; mode[1] = 0;
    dpend[0] = 1'b0; dpend[1] = 1'b0;
    rr_mode = 1;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic wait_ids(input int n);
    int b = 0;
    while (ids.size() < n && b < 80) begin
      tick();
      b++;
    end
    if (ids.size() < n) chk("wait_timeout", ids.size(), n);
  endtask

  // CLR_CYC=2, LAT=1 instance: accept at t, RUN at t+3, result at t+4
  task automatic sweep_op(input logic [WL-1:0] a, input logic [WL-1:0] b);
    int n = 0;
    @(posedge clk);
    #1;
    v2 = 1'b1; x2 = a; y2 = b;
    do begin
      @(negedge clk);
      n++;
    end while (!bus2.req0_ready && n < 20);
    chk("sw_accept", bus2.req0_ready, 1);
    @(posedge clk);
    #1;
    v2 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("sw_mul_rst", bus2.mul_rst, (k > CLR2) && (k <= CLR2 + LT2 + 1));
      chk("sw_res_valid", bus2.res_valid, k == CLR2 + LT2 + 1);
      if (k == CLR2 + LT2 + 1) begin
        chk("sw_res_z", bus2.res_z, {a, b});
        chk("sw_res_id", bus2.res_id, 0);
      end
    end
  endtask

  int base, b;

  initial begin
    v[0] = 1'b0; v[1] = 1'b0;
    x[0] = '0; x[1] = '0; y[0] = '0; y[1] = '0;
    dx[0] = '0; dx[1] = '0; dy[0] = '0; dy[1] = '0;
    dpend[0] = 1'b0; dpend[1] = 1'b0;
    mode[0] = 0; mode[1] = 0;
    rr_mode = 1; rdy = 1'b1;
    v2 = 1'b0; x2 = '0; y2 = '0;
    #2 rst = 1'b0;
    #1 chk_reset();
    tick(); tick();
    rst = 1'b1;

    // single request
    do_reset();
    base = ids.size();
    dx[0] = 8'b10101010; dy[0] = 8'b10001010; dpend[0] = 1'b1;
    wait_ids(base + 1);
    if (ids.size() > base) begin
      chk("single_id", ids[base], 0);
      chk("single_z", zlog[base], 16'hAA8A);
    end

    // simultaneous requests, then a second tie to probe the pointer
    do_reset();
    base = ids.size();
    dx[0] = 8'h11; dy[0] = 8'h22; dx[1] = 8'h33; dy[1] = 8'h44;
    dpend[0] = 1'b1; dpend[1] = 1'b1;
    wait_ids(base + 2);
    if (ids.size() > base + 1) begin
      chk("sim_id0", ids[base], 0);
      chk("sim_z0", zlog[base], 16'h1122);
      chk("sim_id1", ids[base + 1], 1);
      chk("sim_z1", zlog[base + 1], 16'h3344);
    end
    dx[0] = 8'h5a; dy[0] = 8'h01; dx[1] = 8'hc3; dy[1] = 8'h7e;
    dpend[0] = 1'b1; dpend[1] = 1'b1;
    wait_ids(base + 4);
    if (ids.size() > base + 3) begin
      chk("ptr_after2_id0", ids[base + 2], 0);
      chk("ptr_after2_id1", ids[base + 3], 1);
    end

    // fairness under continuous contention
    do_reset();
    base = ids.size();
    mode[0] = 1; mode[1] = 1;
    wait_ids(base + 6);
    mode[0] = 0; mode[1] = 0;
    if (ids.size() > base + 5)
      for (int i = 0; i < 6; i++) chk("fair_id", ids[base + i], i % 2);

    // backpressure: result held 10 cycles while both requesters wait
    do_reset();
    rr_mode = 0;
    dx[0] = 8'h9c; dy[0] = 8'h3f; dpend[0] = 1'b1;
    b = 0;
    while (!bus.res_valid && b < 20) begin
      tick();
      b++;
    end
    chk("bp_res_valid", bus.res_valid, 1);
    mode[0] = 1; mode[1] = 1;
    repeat (10) tick();
    rr_mode = 1;
    repeat (3) tick();
    chk("bp_accept_gap", acc_gap, 1);
    mode[0] = 0; mode[1] = 0;

    // async reset in the middle of RUN abandons the op
    do_reset();
    dx[0] = 8'h77; dy[0] = 8'h21; dpend[0] = 1'b1;
    b = 0;
    do begin
      tick();
      b++;
    end while (!hs[0] && b < 20);
    chk("mr_accept", hs[0], 1);
    tick(); tick();
    #2;
    do_reset();
    repeat (8) tick();
    base = ids.size();
    chk("mr_no_result", base, ids.size());
    dx[1] = 8'he4; dy[1] = 8'h0b; dpend[1] = 1'b1;
    wait_ids(base + 1);
    if (ids.size() > base) begin
      chk("mr_next_id", ids[base], 1);
      chk("mr_next_z", zlog[base], 16'he40b);
    end

    // randomized traffic with random backpressure
    do_reset();
    base = ids.size();
    mode[0] = 2; mode[1] = 2; rr_mode = 2;
    repeat (500) tick();
    chk("rand_progress", ids.size() > base + 20, 1);

    // CLR_CYC=2, LAT=1 instance
    do_reset();
    repeat (3) sweep_op(WL'($urandom), WL'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
